// File: rtl/clean_point_serializer.sv
// clean_point_serializer
// Buffers 128-bit clean points arriving on a valid-only stream in a small FIFO
// and replays each one as 32-bit words (most significant word first) on a
// valid/ready link. The upstream stream cannot be stalled, so a full FIFO
// drops the incoming point and records it in a sticky flag and a saturating
// counter.
//
// Optional feature: define SERIALIZER_CHECKSUM_EN to append a fifth word per
// point carrying the XOR of the four data words. In that build out_last marks
// the checksum word instead of data word 3.

module clean_point_serializer #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic [127:0]             clean_point,
    input  logic                     clear_ovf,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [31:0]              out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

`ifdef SERIALIZER_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CHK  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
    } state_t;
`endif

    // Point storage; entries need no reset because the pointers define what is valid
    logic [127:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    // Serializer datapath
    state_t          state;
    state_t          next_state;
    logic [127:0]    hold;
    logic [1:0]      word_idx;

    // Handshake and FIFO control strobes
    logic            fifo_empty;
    logic            fifo_full;
    logic            handshake;
    logic            pop;
    logic            push;
    logic            drop;

`ifdef SERIALIZER_CHECKSUM_EN
    logic [31:0]     checksum;
    assign checksum = hold[127:96] ^ hold[95:64] ^ hold[63:32] ^ hold[31:0];
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign out_valid  = (state != IDLE);
    assign busy       = (state != IDLE);
    assign handshake  = out_valid && out_ready;
    assign fifo_count = count;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a point then
    assign push = valid_in && (!fifo_full || pop);
    assign drop = valid_in && !push;

    // Next-state logic; also decides when the FIFO head moves into the hold register
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                if (handshake && (word_idx == 2'd3)) begin
`ifdef SERIALIZER_CHECKSUM_EN
                    next_state = CHK;
`else
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = SEND;
                    end else begin
                        next_state = IDLE;
                    end
`endif
                end
            end
`ifdef SERIALIZER_CHECKSUM_EN
            CHK: begin
                if (handshake) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = SEND;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output word selection, driven purely from registered state so it holds during stalls
    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        case (state)
            SEND: begin
                case (word_idx)
                    2'd0:    out_data = hold[127:96];
                    2'd1:    out_data = hold[95:64];
                    2'd2:    out_data = hold[63:32];
                    default: out_data = hold[31:0];
                endcase
`ifndef SERIALIZER_CHECKSUM_EN
                out_last = (word_idx == 2'd3);
`endif
            end
`ifdef SERIALIZER_CHECKSUM_EN
            CHK: begin
                out_data = checksum;
                out_last = 1'b1;
            end
`endif
            default: begin
                out_data = '0;
                out_last = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Hold register and word index: reload on pop, advance on each accepted data word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold     <= '0;
            word_idx <= '0;
        end else if (pop) begin
            hold     <= mem[rd_ptr];
            word_idx <= '0;
        end else if (handshake && (state == SEND)) begin
            word_idx <= word_idx + 2'd1;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= clean_point;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Drop bookkeeping; a drop coinciding with a clear counts as the first drop after it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_ovf) begin
            overflow   <= drop;
            drop_count <= drop ? DROP_W'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != {DROP_W{1'b1}}) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clean_point_serializer.sv
// tb_clean_point_serializer
// Drives points into clean_point_serializer, queues the words each accepted
// point should produce, and compares them against every handshaken output
// word. Status outputs are checked directly around stalls, overflow and reset.

module tb_clean_point_serializer;

    localparam int DEPTH  = 8;
    localparam int DROP_W = 16;
`ifdef SERIALIZER_CHECKSUM_EN
    localparam int WPP = 5;
`else
    localparam int WPP = 4;
`endif

    logic                   clk;
    logic                   reset;
    logic                   valid_in;
    logic [127:0]           clean_point;
    logic                   clear_ovf;
    logic                   out_ready;
    logic                   out_valid;
    logic [31:0]            out_data;
    logic                   out_last;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic [DROP_W-1:0]      drop_count;
    logic                   busy;

    clean_point_serializer #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .clean_point (clean_point),
        .clear_ovf   (clear_ovf),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .busy        (busy)
    );

    typedef struct packed {
        logic [127:0] point;
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic [31:0]  w2;
        logic [31:0]  w3;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    localparam logic [127:0] P1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t tv[4];
    int   n_vec = 0;
    int   n_err = 0;

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run wanders off
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic expect_words(input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3);
        sb_q.push_back('{data: w0, last: 1'b0});
        sb_q.push_back('{data: w1, last: 1'b0});
        sb_q.push_back('{data: w2, last: 1'b0});
`ifdef SERIALIZER_CHECKSUM_EN
        sb_q.push_back('{data: w3, last: 1'b0});
        sb_q.push_back('{data: w0 ^ w1 ^ w2 ^ w3, last: 1'b1});
`else
        sb_q.push_back('{data: w3, last: 1'b1});
`endif
    endtask

    task automatic expect_point(input logic [127:0] p);
        expect_words(p[127:96], p[95:64], p[63:32], p[31:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one point for exactly one rising edge
    task automatic apply_stimulus(input logic [127:0] p);
        valid_in    = 1'b1;
        clean_point = p;
        tick();
        valid_in    = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sb_q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("[TB] FAIL drain_timeout: got %0d words pending, expected 0", sb_q.size());
        end
    endtask

    // Scoreboard: every accepted output word must match the head of the queue
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("[TB] FAIL unexpected_word: got %0h, expected no word", out_data);
            end else begin
                mon_e = sb_q.pop_front();
                check_output("word_data", 128'(out_data), 128'(mon_e.data));
                check_output("word_last", 128'(out_last), 128'(mon_e.last));
            end
        end
    end

    initial begin
        tv[0] = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tv[1] = {128'h0,
                 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        tv[2] = {128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0,
                 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 32'h9ABC_DEF0};
        tv[3] = {128'h8000_0000_0000_0001_A5A5_A5A5_5A5A_5A5A,
                 32'h8000_0000, 32'h0000_0001, 32'hA5A5_A5A5, 32'h5A5A_5A5A};

        reset       = 1'b0;
        valid_in    = 1'b0;
        clean_point = '0;
        clear_ovf   = 1'b0;
        out_ready   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_out_valid",  128'(out_valid),  128'd0);
        check_output("rst_out_data",   128'(out_data),   128'd0);
        check_output("rst_out_last",   128'(out_last),   128'd0);
        check_output("rst_fifo_count", 128'(fifo_count), 128'd0);
        check_output("rst_overflow",   128'(overflow),   128'd0);
        check_output("rst_drop_count", 128'(drop_count), 128'd0);
        check_output("rst_busy",       128'(busy),       128'd0);
        reset = 1'b1;
        tick();

        // Single point: first word two cycles after valid_in
        out_ready = 1'b1;
        expect_words(32'h0123_4567, 32'h89AB_CDEF, 32'h0011_2233, 32'h4455_6677);
        apply_stimulus(P1);
        @(negedge clk);
        check_output("latency_n1_valid", 128'(out_valid), 128'd0);
        tick();
        @(negedge clk);
        check_output("latency_n2_valid", 128'(out_valid), 128'd1);
        check_output("latency_n2_busy",  128'(busy),      128'd1);
        check_output("latency_n2_data",  128'(out_data),  128'h0123_4567);
        wait_drain(20);
        check_output("idle_busy", 128'(busy), 128'd0);

        // Table of isolated points
        for (int i = 0; i < 4; i++) begin
            expect_words(tv[i].w0, tv[i].w1, tv[i].w2, tv[i].w3);
            apply_stimulus(tv[i].point);
            wait_drain(20);
        end

        // Stall for five cycles while word 1 is on the link
        expect_point(P1);
        apply_stimulus(P1);
        tick();
        tick();
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_output("stall_data",  128'(out_data),  128'h89AB_CDEF);
            check_output("stall_valid", 128'(out_valid), 128'd1);
            check_output("stall_last",  128'(out_last),  128'd0);
        end
        out_ready = 1'b1;
        wait_drain(20);

        // Overflow: ten points with the link stalled, the tenth is dropped
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            logic [127:0] p;
            p = {4{32'h0000_0100 + 32'(i)}};
            if (i < 9) expect_point(p);
            apply_stimulus(p);
        end
        check_output("ovf_fifo_count", 128'(fifo_count), 128'd8);
        check_output("ovf_overflow",   128'(overflow),   128'd1);
        check_output("ovf_drop_count", 128'(drop_count), 128'd1);
        check_output("ovf_busy",       128'(busy),       128'd1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check_output("clr_overflow",   128'(overflow),   128'd0);
        check_output("clr_drop_count", 128'(drop_count), 128'd0);
        apply_stimulus(128'h1);
        apply_stimulus(128'h2);
        check_output("drop2_count",    128'(drop_count), 128'd2);
        clear_ovf = 1'b1;
        apply_stimulus(128'h3);
        clear_ovf = 1'b0;
        check_output("clrdrop_overflow",   128'(overflow),   128'd1);
        check_output("clrdrop_drop_count", 128'(drop_count), 128'd1);
        check_output("clrdrop_fifo_count", 128'(fifo_count), 128'd8);

        // Push into a full FIFO on the same edge the serializer pops: accepted, no drop
        out_ready = 1'b1;
        repeat (WPP - 1) tick();
        expect_point(128'h7777_0000_6666_1111_5555_2222_4444_3333);
        apply_stimulus(128'h7777_0000_6666_1111_5555_2222_4444_3333);
        check_output("fullpp_fifo_count", 128'(fifo_count), 128'd8);
        check_output("fullpp_drop_count", 128'(drop_count), 128'd1);
        wait_drain(200);

        // Two points back to back: no idle cycle between them
        expect_point(128'hA0A0_A0A1_A0A0_A0A2_A0A0_A0A3_A0A0_A0A4);
        expect_point(128'hB0B0_B0B1_B0B0_B0B2_B0B0_B0B3_B0B0_B0B4);
        apply_stimulus(128'hA0A0_A0A1_A0A0_A0A2_A0A0_A0A3_A0A0_A0A4);
        apply_stimulus(128'hB0B0_B0B1_B0B0_B0B2_B0B0_B0B3_B0B0_B0B4);
        for (int i = 0; i < 2 * WPP; i++) begin
            @(negedge clk);
            check_output("b2b_valid", 128'(out_valid), 128'd1);
        end
        @(negedge clk);
        check_output("b2b_end_valid", 128'(out_valid), 128'd0);
        wait_drain(20);

        // Reset in the middle of word 2 with a second point queued
        expect_point(128'hC1C1_C1C1_C2C2_C2C2_C3C3_C3C3_C4C4_C4C4);
        apply_stimulus(128'hC1C1_C1C1_C2C2_C2C2_C3C3_C3C3_C4C4_C4C4);
        apply_stimulus(128'hD1D1_D1D1_D2D2_D2D2_D3D3_D3D3_D4D4_D4D4);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_output("mrst_out_valid",  128'(out_valid),  128'd0);
        check_output("mrst_fifo_count", 128'(fifo_count), 128'd0);
        check_output("mrst_busy",       128'(busy),       128'd0);
        sb_q.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        expect_point(128'hE1E1_E1E1_E2E2_E2E2_E3E3_E3E3_E4E4_E4E4);
        apply_stimulus(128'hE1E1_E1E1_E2E2_E2E2_E3E3_E3E3_E4E4_E4E4);
        wait_drain(20);

        check_output("final_queue", 128'(sb_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
